multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter IO_ADDR_BITS, default 22: low address bits that must be all ones to select the IO space.
REQ-002 SHALL have parameter MEM_LAT, default 2, range 1..15: data-memory access latency in cycles.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port inst, input, 32: instruction word from instruction memory.
REQ-006 SHALL have port imem_ready, input, 1: inst is valid this cycle.
REQ-007 SHALL have port alu_result, input, 32: effective address or ALU output.
REQ-008 SHALL have port branch_taken, input, 1: comparator outcome, valid in EXEC.
REQ-009 SHALL have port io_ready, input, 1: IO device completes the current access.
REQ-010 SHALL have outputs ir_write, pc_write, reg_write, mem_read, mem_write, io_read, io_write and mem_or_io_to_reg, each 1 bit: phase-qualified strobes.
REQ-011 SHALL have outputs alu_src, branch and jump, each 1 bit; alu_op, 2 bits; branch_type, 3 bits; mem_size, 2 bits; mem_unsigned, 1 bit.
REQ-012 SHALL have outputs illegal_inst, 1 bit (sticky error) and state, 3 bits (current FSM state).

Function
REQ-013 SHALL sequence the states FETCH, DECODE, EXEC, MEM, IOWAIT, WB and TRAP.
REQ-014 FETCH SHALL wait for imem_ready; when it is 1, SHALL pulse ir_write, latch inst into an internal IR and go to DECODE.
REQ-015 DECODE SHALL classify IR[6:0]: R (0110011), I (0010011), LOAD (0000011), STORE (0100011), BRANCH (1100011), JAL (1101111), JALR (1100111), LUI (0110111); any other opcode SHALL go to TRAP.
REQ-016 alu_op SHALL be 10 for R, 01 for BRANCH, 00 otherwise; alu_src SHALL be 1 for I, LOAD, STORE and JALR; all decode outputs SHALL derive from the latched IR, never from inst.
REQ-017 EXEC SHALL last exactly 1 cycle. LOAD/STORE go to MEM or IOWAIT; BRANCH and JAL/JALR go to FETCH with pc_write=1; jump=1 for JAL/JALR; branch=1 with branch_type=IR[14:12]; all other classes go to WB.
REQ-018 Address decode: IO is selected when alu_result[IO_ADDR_BITS-1:0] is all ones, memory otherwise; the selection SHALL be registered at the end of EXEC.
REQ-019 MEM SHALL hold mem_read or mem_write for exactly MEM_LAT cycles using a down-counter; a load then goes to WB and a store to FETCH with pc_write=1.
REQ-020 IOWAIT SHALL hold io_read or io_write until io_ready=1 and SHALL be unbounded; on the io_ready cycle it exits as MEM does.
REQ-021 WB SHALL pulse reg_write and pc_write for 1 cycle, then go to FETCH; mem_or_io_to_reg=1 in WB for loads only.
REQ-022 reg_write SHALL never assert when IR[11:7]=0 (x0 writes suppressed); the PC still advances.
REQ-023 TRAP SHALL set illegal_inst, hold every strobe at 0 and stay there until reset.
REQ-024 Baseline instruction lengths (R, I, LUI 4 cycles; load MEM_LAT+4; store MEM_LAT+3; branch and jump 3) SHALL be the cycle counts with imem_ready=1 throughout.

Reset
REQ-025 rst_n=0 SHALL immediately force FETCH, clear IR, the counter, the IO select and illegal_inst, and drive every strobe to 0, including mid-MEM and mid-IOWAIT; the first FETCH follows the first clk edge after release.

Configuration
REQ-026 With CTRL_SUBWORD_EN defined, funct3 000/001/010/100/101 on loads and 000/001/010 on stores SHALL be legal; mem_size = funct3[1:0] and mem_unsigned = funct3[2].
REQ-027 Without CTRL_SUBWORD_EN, only funct3=010 (word) SHALL be legal for LOAD/STORE, other values go to TRAP, and mem_size=10 and mem_unsigned=0 are constant.

Structure
REQ-028 Opcode localparams, the state encoding and the alu_op codes SHALL live in the shared package ctrl_pkg.
REQ-029 Combinational IR decode SHALL be the sub-module inst_decoder; the FSM, counter and address decode SHALL stay in multicycle_controller.

Verification
REQ-030 add x1,x2,x3 (0x003100B3), imem_ready=1: FETCH, DECODE, EXEC, WB; reg_write and pc_write high only in WB.
REQ-031 lw with alu_result=0x00001000 and MEM_LAT=2: mem_read high for exactly 2 cycles, then WB with mem_or_io_to_reg=1.
REQ-032 sw with alu_result=0xFFFFFFFF and io_ready low for 5 cycles: io_write high for 6 cycles, mem_write never high, then FETCH with pc_write=1.
REQ-033 addi x0,x0,1 (0x00100013): the WB cycle occurs but reg_write stays 0.
REQ-034 opcode 0x7F: TRAP and illegal_inst=1; rst_n pulsed low during a MEM load clears state to FETCH with all strobes 0 asynchronously.
REQ-035 lh (funct3=001): with CTRL_SUBWORD_EN, mem_size=01 and mem_unsigned=0; without it, TRAP.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: opcodes, FSM state
// encoding, instruction classes and ALU operation codes.
package ctrl_pkg;

   // Base opcodes recognised by the decoder (IR[6:0])
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // ALU operation selects
   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_BRANCH = 2'b01;
   localparam logic [1:0] ALU_RTYPE  = 2'b10;

   // Word access size used when sub-word accesses are not supported
   localparam logic [1:0] SIZE_WORD  = 2'b10;

   // Width of the memory latency down-counter (MEM_LAT is 1..15)
   localparam int CNT_W = 4;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_IOWAIT = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } state_t;

   typedef enum logic [3:0] {
      CLS_R       = 4'd0,
      CLS_I       = 4'd1,
      CLS_LOAD    = 4'd2,
      CLS_STORE   = 4'd3,
      CLS_BRANCH  = 4'd4,
      CLS_JAL     = 4'd5,
      CLS_JALR    = 4'd6,
      CLS_LUI     = 4'd7,
      CLS_ILLEGAL = 4'd8
   } inst_class_t;

endpackage

// File: rtl/inst_decoder.sv
// Combinational decode of the latched instruction register.
// Optional feature macro: CTRL_SUBWORD_EN enables byte/halfword loads and
// stores; without it only word accesses are legal.
module inst_decoder
   import ctrl_pkg::*;
(
   input  logic [14:0]  ir_bits,
   output inst_class_t  inst_class,
   output logic         legal,
   output logic [1:0]   alu_op,
   output logic         alu_src,
   output logic [2:0]   branch_type,
   output logic [1:0]   mem_size,
   output logic         mem_unsigned,
   output logic         rd_nonzero
);

   logic [6:0] opcode;
   logic [2:0] funct3;

   assign opcode      = ir_bits[6:0];
   assign funct3      = ir_bits[14:12];
   assign rd_nonzero  = |ir_bits[11:7];
   assign branch_type = funct3;

   // Classify the opcode and check that load/store widths are supported
   always_comb begin
      inst_class = CLS_ILLEGAL;
      legal      = 1'b1;
      case (opcode)
         OP_R:      inst_class = CLS_R;
         OP_I:      inst_class = CLS_I;
         OP_BRANCH: inst_class = CLS_BRANCH;
         OP_JAL:    inst_class = CLS_JAL;
         OP_JALR:   inst_class = CLS_JALR;
         OP_LUI:    inst_class = CLS_LUI;
         OP_LOAD: begin
            inst_class = CLS_LOAD;
`ifdef CTRL_SUBWORD_EN
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
`else
            legal = (funct3 == 3'b010);
`endif
         end
         OP_STORE: begin
            inst_class = CLS_STORE;
`ifdef CTRL_SUBWORD_EN
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
`else
            legal = (funct3 == 3'b010);
`endif
         end
         default:   legal = 1'b0;
      endcase
   end

   assign alu_op  = (inst_class == CLS_R)      ? ALU_RTYPE  :
                    (inst_class == CLS_BRANCH) ? ALU_BRANCH : ALU_ADD;
   assign alu_src = (inst_class == CLS_I) || (inst_class == CLS_LOAD) ||
                    (inst_class == CLS_STORE) || (inst_class == CLS_JALR);

`ifdef CTRL_SUBWORD_EN
   assign mem_size     = funct3[1:0];
   assign mem_unsigned = funct3[2];
`else
   assign mem_size     = SIZE_WORD;
   assign mem_unsigned = 1'b0;
`endif

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle FSM controller: fetch, decode, execute, memory/IO access and
// write-back, with an unbounded IO wait and a sticky illegal-instruction trap.
// Sub-word load/store support is selected by CTRL_SUBWORD_EN (see inst_decoder).
module multicycle_controller
   import ctrl_pkg::*;
#(
   parameter int IO_ADDR_BITS = 22,
   parameter int MEM_LAT      = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst,
   input  logic        imem_ready,
   input  logic [31:0] alu_result,
   input  logic        branch_taken,
   input  logic        io_ready,
   output logic        ir_write,
   output logic        pc_write,
   output logic        reg_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        io_read,
   output logic        io_write,
   output logic        mem_or_io_to_reg,
   output logic        alu_src,
   output logic        branch,
   output logic        jump,
   output logic [1:0]  alu_op,
   output logic [2:0]  branch_type,
   output logic [1:0]  mem_size,
   output logic        mem_unsigned,
   output logic        illegal_inst,
   output logic [2:0]  state
);

   state_t             state_reg;
   logic [31:0]        ir_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic               io_sel_reg;
   logic               illegal_reg;
   logic               run_reg;

   inst_class_t        inst_class;
   logic               legal;
   logic               rd_nonzero;
   logic               is_load, is_store, is_branch, is_jump;
   logic               addr_is_io;
   logic               unused_bits;

   inst_decoder u_dec (
      .ir_bits      (ir_reg[14:0]),
      .inst_class   (inst_class),
      .legal        (legal),
      .alu_op       (alu_op),
      .alu_src      (alu_src),
      .branch_type  (branch_type),
      .mem_size     (mem_size),
      .mem_unsigned (mem_unsigned),
      .rd_nonzero   (rd_nonzero)
   );

   assign is_load    = (inst_class == CLS_LOAD);
   assign is_store   = (inst_class == CLS_STORE);
   assign is_branch  = (inst_class == CLS_BRANCH);
   assign is_jump    = (inst_class == CLS_JAL) || (inst_class == CLS_JALR);
   assign addr_is_io = &alu_result[IO_ADDR_BITS-1:0];

   // The comparator result is consumed by the datapath, not the sequencer
   assign unused_bits = ^{ir_reg[31:15], alu_result, branch_taken};

   assign state        = state_reg;
   assign illegal_inst = illegal_reg;

   // State sequencing, IR latch, latency counter, IO select and sticky error;
   // run_reg holds the FSM idle until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_FETCH;
         ir_reg      <= '0;
         cnt_reg     <= '0;
         io_sel_reg  <= 1'b0;
         illegal_reg <= 1'b0;
         run_reg     <= 1'b0;
      end else if (!run_reg) begin
         run_reg <= 1'b1;
      end else begin
         case (state_reg)
            ST_FETCH: begin
               if (imem_ready) begin
                  ir_reg    <= inst;
                  state_reg <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (legal) begin
                  state_reg <= ST_EXEC;
               end else begin
                  state_reg   <= ST_TRAP;
                  illegal_reg <= 1'b1;
               end
            end
            ST_EXEC: begin
               io_sel_reg <= addr_is_io;
               cnt_reg    <= CNT_W'(MEM_LAT);
               case (inst_class)
                  CLS_LOAD, CLS_STORE:         state_reg <= addr_is_io ? ST_IOWAIT : ST_MEM;
                  CLS_BRANCH, CLS_JAL, CLS_JALR: state_reg <= ST_FETCH;
                  default:                     state_reg <= ST_WB;
               endcase
            end
            ST_MEM: begin
               cnt_reg <= cnt_reg - 1'b1;
               if (cnt_reg <= CNT_W'(1)) begin
                  state_reg <= is_load ? ST_WB : ST_FETCH;
               end
            end
            ST_IOWAIT: begin
               if (io_ready) begin
                  state_reg <= is_load ? ST_WB : ST_FETCH;
               end
            end
            ST_WB:   state_reg <= ST_FETCH;
            ST_TRAP: state_reg <= ST_TRAP;
            default: state_reg <= ST_FETCH;
         endcase
      end
   end

   // Phase-qualified strobes; all forced low while reset or idle after reset
   always_comb begin
      ir_write         = 1'b0;
      pc_write         = 1'b0;
      reg_write        = 1'b0;
      mem_read         = 1'b0;
      mem_write        = 1'b0;
      io_read          = 1'b0;
      io_write         = 1'b0;
      mem_or_io_to_reg = 1'b0;
      branch           = 1'b0;
      jump             = 1'b0;
      if (run_reg) begin
         case (state_reg)
            ST_FETCH: ir_write = imem_ready;
            ST_EXEC: begin
               branch   = is_branch;
               jump     = is_jump;
               pc_write = is_branch || is_jump;
            end
            ST_MEM: begin
               mem_read  = is_load && !io_sel_reg;
               mem_write = is_store && !io_sel_reg;
               pc_write  = is_store && (cnt_reg == CNT_W'(1));
            end
            ST_IOWAIT: begin
               io_read  = is_load && io_sel_reg;
               io_write = is_store && io_sel_reg;
               pc_write = is_store && io_ready;
            end
            ST_WB: begin
               reg_write        = rd_nonzero;
               pc_write         = 1'b1;
               mem_or_io_to_reg = is_load;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised self-checking bench for multicycle_controller. Each instruction
// is turned into a per-cycle expectation script from the instruction timing
// rules, then played against the DUT.
module tb_multicycle_controller;
   import ctrl_pkg::*;

   localparam int TB_IO_BITS = 22;
   localparam int TB_LAT     = 2;

   localparam logic [7:0] S_IRW = 8'h80;
   localparam logic [7:0] S_PCW = 8'h40;
   localparam logic [7:0] S_RW  = 8'h20;
   localparam logic [7:0] S_MR  = 8'h10;
   localparam logic [7:0] S_MW  = 8'h08;
   localparam logic [7:0] S_IOR = 8'h04;
   localparam logic [7:0] S_IOW = 8'h02;
   localparam logic [7:0] S_MTR = 8'h01;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst, alu_result;
   logic        imem_ready, branch_taken, io_ready;
   logic        ir_write, pc_write, reg_write, mem_read, mem_write;
   logic        io_read, io_write, mem_or_io_to_reg;
   logic        alu_src, branch, jump, mem_unsigned, illegal_inst;
   logic [1:0]  alu_op, mem_size;
   logic [2:0]  branch_type, state;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic       imem;
      logic       iord;
      logic [2:0] st;
      logic [7:0] stb;
      logic       br;
      logic       jp;
      logic       il;
   } cyc_t;

   always #5 clk = ~clk;

   multicycle_controller #(.IO_ADDR_BITS(TB_IO_BITS), .MEM_LAT(TB_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .inst(inst), .imem_ready(imem_ready),
      .alu_result(alu_result), .branch_taken(branch_taken), .io_ready(io_ready),
      .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .mem_read(mem_read), .mem_write(mem_write), .io_read(io_read),
      .io_write(io_write), .mem_or_io_to_reg(mem_or_io_to_reg),
      .alu_src(alu_src), .branch(branch), .jump(jump), .alu_op(alu_op),
      .branch_type(branch_type), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
      .illegal_inst(illegal_inst), .state(state)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] strobes();
      return {ir_write, pc_write, reg_write, mem_read, mem_write, io_read, io_write, mem_or_io_to_reg};
   endfunction

   function automatic cyc_t mk(logic im, logic io, logic [2:0] s, logic [7:0] sb,
                               logic b, logic j, logic il);
      cyc_t c;
      c.imem = im; c.iord = io; c.st = s; c.stb = sb; c.br = b; c.jp = j; c.il = il;
      return c;
   endfunction

   function automatic bit ls_legal(bit ld, logic [2:0] f3);
`ifdef CTRL_SUBWORD_EN
      if (ld) return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      return f3 inside {3'b000, 3'b001, 3'b010};
`else
      return f3 == 3'b010;
`endif
   endfunction

   // Assert reset asynchronously, check its immediate effect, then release
   task automatic do_reset(input string name);
      #1 rst_n = 1'b0;
      #1;
      check_eq({name, " rst state"},   32'(state), 32'(ST_FETCH));
      check_eq({name, " rst strobes"}, 32'(strobes()), 32'h0);
      check_eq({name, " rst illegal"}, 32'(illegal_inst), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      imem_ready = 1'b0;
   endtask

   // Build the expected cycle script for one instruction and play it;
   // abort_at >= 0 pulses reset right after that script entry
   task automatic run_inst(input string name, input logic [31:0] ins, input logic [31:0] addr,
                           input int w, input int k, input int abort_at);
      cyc_t       q[$];
      logic [6:0] op;
      logic [2:0] f3;
      bit         rd_nz, is_io, ld, sto, br, jp, wbc, legal;
      logic [7:0] sb;
      logic [1:0] exp_aop, exp_size;
      bit         exp_src, exp_uns;
      string      tag;

      op    = ins[6:0];
      f3    = ins[14:12];
      rd_nz = (ins[11:7] != 5'd0);
      is_io = &addr[TB_IO_BITS-1:0];
      ld    = (op == 7'h03);
      sto   = (op == 7'h23);
      br    = (op == 7'h63);
      jp    = (op == 7'h6F) || (op == 7'h67);
      wbc   = (op == 7'h33) || (op == 7'h13) || (op == 7'h37);
      legal = wbc || br || jp || ((ld || sto) && ls_legal(ld, f3));
      exp_aop = (op == 7'h33) ? 2'b10 : (br ? 2'b01 : 2'b00);
      exp_src = (op == 7'h13) || ld || sto || (op == 7'h67);
`ifdef CTRL_SUBWORD_EN
      exp_size = f3[1:0];
      exp_uns  = f3[2];
`else
      exp_size = 2'b10;
      exp_uns  = 1'b0;
`endif

      for (int i = 0; i < w; i++) q.push_back(mk(1'b0, 1'b0, ST_FETCH, 8'h0, 1'b0, 1'b0, 1'b0));
      q.push_back(mk(1'b1, 1'b0, ST_FETCH, S_IRW, 1'b0, 1'b0, 1'b0));
      q.push_back(mk(1'b0, 1'b0, ST_DECODE, 8'h0, 1'b0, 1'b0, 1'b0));
      if (!legal) begin
         for (int i = 0; i < 3; i++) q.push_back(mk(1'b0, 1'b0, ST_TRAP, 8'h0, 1'b0, 1'b0, 1'b1));
      end else begin
         q.push_back(mk(1'b0, 1'b0, ST_EXEC, (br || jp) ? S_PCW : 8'h0, br, jp, 1'b0));
         if ((ld || sto) && !is_io) begin
            for (int i = 0; i < TB_LAT; i++) begin
               sb = ld ? S_MR : (S_MW | ((i == TB_LAT - 1) ? S_PCW : 8'h0));
               q.push_back(mk(1'b0, 1'b0, ST_MEM, sb, 1'b0, 1'b0, 1'b0));
            end
         end else if (ld || sto) begin
            for (int i = 0; i <= k; i++) begin
               sb = ld ? S_IOR : (S_IOW | ((i == k) ? S_PCW : 8'h0));
               q.push_back(mk(1'b0, (i == k), ST_IOWAIT, sb, 1'b0, 1'b0, 1'b0));
            end
         end
         if (ld || wbc) begin
            sb = S_PCW | (rd_nz ? S_RW : 8'h0) | (ld ? S_MTR : 8'h0);
            q.push_back(mk(1'b0, 1'b0, ST_WB, sb, 1'b0, 1'b0, 1'b0));
         end
      end

      for (int i = 0; i < q.size(); i++) begin
         @(posedge clk);
         #1;
         imem_ready   = (q[i].st == ST_FETCH)  ? q[i].imem : 1'($urandom);
         io_ready     = (q[i].st == ST_IOWAIT) ? q[i].iord : 1'($urandom);
         inst         = (q[i].st == ST_FETCH && q[i].imem) ? ins : $urandom;
         alu_result   = (q[i].st == ST_EXEC) ? addr : $urandom;
         branch_taken = 1'($urandom);
         @(negedge clk);
         tag = $sformatf("%s c%0d", name, i);
         check_eq({tag, " state"},   32'(state), 32'(q[i].st));
         check_eq({tag, " strobes"}, 32'(strobes()), 32'(q[i].stb));
         check_eq({tag, " illegal"}, 32'(illegal_inst), 32'(q[i].il));
         if (q[i].st == ST_EXEC) begin
            check_eq({tag, " branch"},  32'(branch), 32'(q[i].br));
            check_eq({tag, " jump"},    32'(jump), 32'(q[i].jp));
            check_eq({tag, " alu_op"},  32'(alu_op), 32'(exp_aop));
            check_eq({tag, " alu_src"}, 32'(alu_src), 32'(exp_src));
            if (br) check_eq({tag, " branch_type"}, 32'(branch_type), 32'(f3));
            if (ld || sto) begin
               check_eq({tag, " mem_size"},     32'(mem_size), 32'(exp_size));
               check_eq({tag, " mem_unsigned"}, 32'(mem_unsigned), 32'(exp_uns));
            end
         end
         if (i == abort_at) begin
            $display("inst %s %08h addr %08h: reset after cycle %0d", name, ins, addr, i);
            do_reset(name);
            return;
         end
      end
      $display("inst %s %08h addr %08h: %0d cycles%s", name, ins, addr, q.size(),
               legal ? "" : " (trap)");
      if (!legal) do_reset(name);
   endtask

   logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h7F, 7'h0B};
   logic [31:0] rins, raddr;

   initial begin
      rst_n = 1'b0; inst = '0; alu_result = '0; branch_taken = 1'b0;
      imem_ready = 1'b1; io_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("reset state",   32'(state), 32'(ST_FETCH));
      check_eq("reset strobes", 32'(strobes()), 32'h0);
      check_eq("reset illegal", 32'(illegal_inst), 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      imem_ready = 1'b0;

      run_inst("add",      32'h003100B3, 32'h0000_0040, 0, 0, -1);
      run_inst("lw",       32'h0000A283, 32'h0000_1000, 1, 0, -1);
      run_inst("sw_io",    32'h0020A023, 32'hFFFF_FFFF, 0, 5, -1);
      run_inst("addi_x0",  32'h00100013, 32'h0000_0000, 0, 0, -1);
      run_inst("beq",      32'h00208463, 32'h1234_5678, 2, 0, -1);
      run_inst("jal",      32'h008000EF, 32'h0000_0000, 0, 0, -1);
      run_inst("lw_io",    32'h0000A283, 32'h003F_FFFF, 0, 2, -1);
      run_inst("sw_mem",   32'h0020A023, 32'h0000_2000, 0, 0, -1);
      run_inst("illegal",  32'h0000007F, 32'h0000_0000, 0, 0, -1);
      run_inst("lw_rst",   32'h0000A283, 32'h0000_1000, 0, 0, 3);
      run_inst("lh",       32'h00009283, 32'h0000_1002, 0, 0, -1);
      run_inst("lui",      32'h123452B7, 32'h0000_0000, 0, 0, -1);

      for (int n = 0; n < 60; n++) begin
         rins = $urandom;
         rins[6:0] = ops[$urandom_range(0, 9)];
         if ($urandom_range(0, 7) == 0) rins[11:7] = 5'd0;
         if ($urandom_range(0, 1) == 1) raddr = $urandom | 32'h003F_FFFF;
         else raddr = $urandom & ~(32'h1 << $urandom_range(0, TB_IO_BITS - 1));
         run_inst($sformatf("rnd%0d", n), rins, raddr, $urandom_range(0, 2),
                  $urandom_range(0, 4), -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
